// File: rtl/fifo_rd_skid_pkg.sv
// rtl/fifo_rd_skid_pkg.sv - shared types and constants for the FIFO read-side skid adapter
package fifo_rd_skid_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int SKID_DEPTH           = 2;
  localparam int CNT_W                = $clog2(SKID_DEPTH + 1);
  localparam int RSTBUSY_QUIET_CYCLES = 2;
  localparam int QUIET_W              = $clog2(RSTBUSY_QUIET_CYCLES + 1);

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// rtl/fifo_rd_skid_buf.sv - 2-entry skid storage with head/tail slot pointers and occupancy count
module fifo_rd_skid_buf
  import fifo_rd_skid_pkg::*;
#(
  parameter int W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     slot_q [SKID_DEPTH];
  logic             head_q;
  logic             tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Simultaneous push and pop leaves the occupancy untouched.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= '0;
    end else if (clear_i) begin
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push_i) begin
        slot_q[tail_q] <= push_data_i;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop_i) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head_data_o = slot_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - FWFT FIFO read adapter: reset-busy gating, 2-entry skid, valid/ready output
// Optional pop/stall counters are built when FIFO_RD_SKID_STATS_EN is defined.
module fifo_rd_skid
  import fifo_rd_skid_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] FIFO_DOUT,
  input  logic         FIFO_EMPTY_N,
  input  logic         FIFO_RDRSTBUSY,
  output logic         FIFO_RDEN,
  output logic [W-1:0] DEQ_DATA,
  output logic         DEQ_VALID,
  input  logic         DEQ_READY,
`ifdef FIFO_RD_SKID_STATS_EN
  output logic [31:0]  STAT_POPS,
  output logic [31:0]  STAT_STALLS,
`endif
  output logic         BUSY
);

  state_e             state_q;
  logic [QUIET_W-1:0] quiet_q;
  logic               busy_q;
  logic [CNT_W-1:0]   count;
  logic               deq;
  logic               buf_clear;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WAIT;
      quiet_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        WAIT: begin
          if (FIFO_RDRSTBUSY) begin
            quiet_q <= '0;
          end else if (quiet_q == QUIET_W'(RSTBUSY_QUIET_CYCLES - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
            quiet_q <= '0;
          end else begin
            quiet_q <= quiet_q + QUIET_W'(1);
          end
        end
        RUN: begin
          if (FIFO_RDRSTBUSY) begin
            state_q <= WAIT;
            busy_q  <= 1'b1;
            quiet_q <= '0;
          end
        end
        default: begin
          state_q <= WAIT;
          busy_q  <= 1'b1;
          quiet_q <= '0;
        end
      endcase
    end
  end

  // Pop uses only registered occupancy, keeping DEQ_READY out of the FIFO_RDEN path.
  assign FIFO_RDEN = (state_q == RUN) && FIFO_EMPTY_N && !FIFO_RDRSTBUSY
                     && (count < CNT_W'(SKID_DEPTH));
  assign DEQ_VALID = (count != '0);
  assign deq       = DEQ_VALID && DEQ_READY;
  assign buf_clear = (state_q != RUN) || FIFO_RDRSTBUSY;
  assign BUSY      = busy_q;

  fifo_rd_skid_buf #(
    .W (W)
  ) u_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clear_i     (buf_clear),
    .push_i      (FIFO_RDEN),
    .push_data_i (FIFO_DOUT),
    .pop_i       (deq),
    .head_data_o (DEQ_DATA),
    .count_o     (count)
  );

`ifdef FIFO_RD_SKID_STATS_EN
  logic [31:0] stat_pops_q;
  logic [31:0] stat_stalls_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_pops_q   <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (FIFO_RDEN && (stat_pops_q != 32'hFFFF_FFFF)) begin
        stat_pops_q <= stat_pops_q + 32'd1;
      end
      if (DEQ_VALID && !DEQ_READY && (stat_stalls_q != 32'hFFFF_FFFF)) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign STAT_POPS   = stat_pops_q;
  assign STAT_STALLS = stat_stalls_q;
`endif

endmodule

// File: tb/tb_fifo_rd_skid.sv
// tb/tb_fifo_rd_skid.sv - randomized scoreboard bench for fifo_rd_skid against a queue-level model
module tb_fifo_rd_skid;

  localparam int W = 64;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] FIFO_DOUT;
  logic         FIFO_EMPTY_N;
  logic         FIFO_RDRSTBUSY;
  logic         FIFO_RDEN;
  logic [W-1:0] DEQ_DATA;
  logic         DEQ_VALID;
  logic         DEQ_READY;
  logic         BUSY;
`ifdef FIFO_RD_SKID_STATS_EN
  logic [31:0]  STAT_POPS;
  logic [31:0]  STAT_STALLS;
`endif

  fifo_rd_skid #(.W(W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .FIFO_DOUT      (FIFO_DOUT),
    .FIFO_EMPTY_N   (FIFO_EMPTY_N),
    .FIFO_RDRSTBUSY (FIFO_RDRSTBUSY),
    .FIFO_RDEN      (FIFO_RDEN),
    .DEQ_DATA       (DEQ_DATA),
    .DEQ_VALID      (DEQ_VALID),
    .DEQ_READY      (DEQ_READY),
`ifdef FIFO_RD_SKID_STATS_EN
    .STAT_POPS      (STAT_POPS),
    .STAT_STALLS    (STAT_STALLS),
`endif
    .BUSY           (BUSY)
  );

  initial forever #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Model: fifo_q is the upstream FIFO, exp_q holds words popped but not yet consumed.
  logic [W-1:0] fifo_q [$];
  logic [W-1:0] exp_q  [$];
  int           zeros    = 0;
  bit           chk_en   = 1'b0;
  bit           rst_seen = 1'b1;
  bit a_rst = 1'b1, a_busy = 1'b1, a_ready = 1'b0, a_gate = 1'b0;
  bit r_rst = 1'b1, r_busy = 1'b1, r_ready = 1'b0, r_gate = 1'b0;
  bit pend_rden = 1'b0, pend_stall = 1'b0, refill_en = 1'b0;
  logic [W-1:0] next_word = 1;
  int cyc = 0, acc_cnt = 0, first_acc = -1, last_acc = -1;
  longint unsigned m_pops = 0, m_stalls = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_ports();
    RST            = a_rst;
    FIFO_RDRSTBUSY = a_busy;
    DEQ_READY      = a_ready;
    FIFO_EMPTY_N   = a_gate && (fifo_q.size() != 0);
    FIFO_DOUT      = (fifo_q.size() != 0) ? fifo_q[0] : W'(64'hBAD0_BAD0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (pend_rden && fifo_q.size() != 0) exp_q.push_back(fifo_q.pop_front());
    if (a_rst || a_busy) begin
      exp_q.delete();
      zeros = 0;
    end else if (zeros < 2) begin
      zeros++;
    end
    if (a_busy) fifo_q.delete();
    if (a_rst) begin
      m_pops   = 0;
      m_stalls = 0;
    end else begin
      m_pops   += longint'(pend_rden);
      m_stalls += longint'(pend_stall);
    end
    rst_seen = a_rst;
    chk_en   = 1'b1;
    a_rst = r_rst; a_busy = r_busy; a_ready = r_ready; a_gate = r_gate;
    if (refill_en) begin
      while (fifo_q.size() < 4) begin
        fifo_q.push_back(next_word);
        next_word++;
      end
    end
    drive_ports();
    @(negedge CLK);
    pend_rden  = FIFO_RDEN;
    pend_stall = DEQ_VALID && !DEQ_READY;
  endtask

  // Monitor: compares DUT outputs with the model every cycle, consumes on handshake.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy", W'(BUSY), W'(zeros < 2));
      check("deq_valid", W'(DEQ_VALID), W'(exp_q.size() != 0));
      check("fifo_rden", W'(FIFO_RDEN),
            W'((zeros >= 2) && FIFO_EMPTY_N && !FIFO_RDRSTBUSY && (exp_q.size() < 2)));
      if (rst_seen) check("reset_data", DEQ_DATA, '0);
      if (DEQ_VALID && exp_q.size() != 0) begin
        check("deq_data", DEQ_DATA, exp_q[0]);
        if (DEQ_READY) begin
          void'(exp_q.pop_front());
          acc_cnt++;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
        end
      end
    end
  end

  initial begin
    int lat;
    int busy_left;
    int stall_left;
    logic [W-1:0] hold_val;
    drive_ports();
    repeat (3) step();

    // Reset release with the FIFO still reporting reset-busy.
    r_rst = 1'b0; r_busy = 1'b1; r_gate = 1'b1; r_ready = 1'b1;
    repeat (10) step();
    r_busy = 1'b0;
    step();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
    next_word = 9;
    lat = -1; acc_cnt = 0; first_acc = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (lat < 0 && pend_rden) lat = i;
    end
    check("rden_latency", W'(lat), W'(2));
    check("stream_count", W'(acc_cnt), W'(8));
    check("stream_span", W'(last_acc - first_acc), W'(7));

    // Backpressure mid-stream.
    refill_en = 1'b1;
    repeat (4) step();
    r_ready = 1'b0;
    step();
    hold_val = DEQ_DATA;
    repeat (4) step();
    check("bp_rden", W'(FIFO_RDEN), W'(0));
    check("bp_valid", W'(DEQ_VALID), W'(1));
    check("bp_hold", DEQ_DATA, hold_val);
    r_ready = 1'b1;
    repeat (6) step();

    // Empty flag toggling.
    for (int k = 0; k < 8; k++) begin
      r_gate = (k % 2 == 0);
      step();
    end
    r_gate = 1'b1;

    // FIFO reset while the buffer is full.
    r_ready = 1'b0;
    repeat (4) step();
    r_busy = 1'b1;
    step();
    step();
    check("flush_valid", W'(DEQ_VALID), W'(0));
    check("flush_busy", W'(BUSY), W'(1));
    step();
    r_busy = 1'b0; r_ready = 1'b1;
    repeat (12) step();

    // Randomized traffic with occasional stalls and FIFO resets.
    busy_left = 0; stall_left = 0;
    repeat (1500) begin
      r_gate = ($urandom_range(2) != 0);
      if (stall_left > 0) begin
        r_ready = 1'b0;
        stall_left--;
      end else begin
        r_ready = ($urandom_range(3) != 0);
        if ($urandom_range(99) == 0) stall_left = 5;
      end
      if (busy_left > 0) begin
        r_busy = 1'b1;
        busy_left--;
      end else begin
        r_busy = 1'b0;
        if ($urandom_range(199) == 0) busy_left = $urandom_range(3, 1);
      end
      step();
    end

    // Drain.
    r_busy = 1'b0; r_ready = 1'b1; r_gate = 1'b0; refill_en = 1'b0;
    repeat (6) step();
    check("drained_valid", W'(DEQ_VALID), W'(0));
`ifdef FIFO_RD_SKID_STATS_EN
    check("stat_pops", W'(STAT_POPS), W'(m_pops));
    check("stat_stalls", W'(STAT_STALLS), W'(m_stalls));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
